// File: rtl/noc_types.sv
// Shared NoC router types: port directions and flit layout.
// The crossbar indexes its ports with the same numbering as e_dir.
package noc_types;

    typedef enum logic [1:0] {
        NORTH = 2'd0,
        EAST  = 2'd1,
        SOUTH = 2'd2,
        WEST  = 2'd3
    } e_dir;

    localparam int NUM_DIRS    = 4;
    localparam int FLIT_DATA_W = 7;

    typedef logic [FLIT_DATA_W-1:0] flit_data_t;

    // Crossbar lanes carry a flit plus its tail marker (flit width + 1).
    typedef struct packed {
        logic       last;
        flit_data_t data;
    } flit_t;

    localparam int FLIT_W = $bits(flit_t);

    // Backpressure lane is packed as {ack, rej}.
    localparam int BP_W       = 2;
    localparam int BP_ACK_BIT = 1;
    localparam int BP_REJ_BIT = 0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter for one crossbar output.
// A still-requesting owner keeps the grant; otherwise scan starts at ptr.
module rr_arbiter #(
    parameter int PORTS = 4
) (
    input  logic [PORTS-1:0]         req,
    input  logic [$clog2(PORTS)-1:0] ptr,
    input  logic                     hold_valid,
    input  logic [$clog2(PORTS)-1:0] hold_idx,
    output logic                     grant_valid,
    output logic [$clog2(PORTS)-1:0] grant_idx,
    output logic                     grant_new
);

    localparam int IDX_W = $clog2(PORTS);

    always_comb begin
        int cand;
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_new   = 1'b0;
        cand        = 0;
        if (hold_valid && req[hold_idx]) begin
            grant_valid = 1'b1;
            grant_idx   = hold_idx;
        end else begin
            for (int k = 0; k < PORTS; k++) begin
                cand = int'(ptr) + k;
                if (cand >= PORTS) begin
                    cand = cand - PORTS;
                end
                if (!grant_valid && req[cand[IDX_W-1:0]]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand[IDX_W-1:0];
                    grant_new   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/crossbar_rr.sv
// PORTS x PORTS combinational crossbar with per-output round-robin ownership.
// Data flows input->output, backpressure flows output->owning input, both zero latency.
module crossbar_rr
    import noc_types::*;
#(
    parameter int PORTS    = 4,
    parameter int WIDTH    = 8,
    parameter int BP_WIDTH = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [PORTS-1:0][WIDTH-1:0]          data_i,
    input  logic [PORTS-1:0][BP_WIDTH-1:0]       bp_i,
    input  logic [PORTS-1:0][$clog2(PORTS)-1:0]  dest,
    input  logic [PORTS-1:0]                     dest_en,
    output logic [PORTS-1:0][WIDTH-1:0]          data_o,
    output logic [PORTS-1:0]                     data_o_en,
    output logic [PORTS-1:0][BP_WIDTH-1:0]       bp_o,
    output logic [PORTS-1:0]                     ack
);

    localparam int IDX_W = $clog2(PORTS);

    logic [PORTS-1:0]            owner_valid_reg, owner_valid_next;
    logic [PORTS-1:0][IDX_W-1:0] owner_idx_reg, owner_idx_next;
    logic [PORTS-1:0][IDX_W-1:0] rr_ptr_reg, rr_ptr_next;

    // req_mat[o][i]: input i is asking for output o this cycle.
    logic [PORTS-1:0][PORTS-1:0] req_mat;
    logic [PORTS-1:0]            grant_valid;
    logic [PORTS-1:0]            grant_new;
    logic [PORTS-1:0][IDX_W-1:0] grant_idx;

    genvar gi, gj;

    generate
        for (gi = 0; gi < PORTS; gi++) begin : g_out
            for (gj = 0; gj < PORTS; gj++) begin : g_req
                assign req_mat[gi][gj] = dest_en[gj] && (dest[gj] == IDX_W'(gi));
            end

            rr_arbiter #(
                .PORTS (PORTS)
            ) u_arb (
                .req         (req_mat[gi]),
                .ptr         (rr_ptr_reg[gi]),
                .hold_valid  (owner_valid_reg[gi]),
                .hold_idx    (owner_idx_reg[gi]),
                .grant_valid (grant_valid[gi]),
                .grant_idx   (grant_idx[gi]),
                .grant_new   (grant_new[gi])
            );

            assign owner_valid_next[gi] = grant_valid[gi];
            assign owner_idx_next[gi]   = grant_idx[gi];
            // Pointer only advances past a fresh winner; a held grant leaves it alone.
            assign rr_ptr_next[gi] = !grant_new[gi] ? rr_ptr_reg[gi] :
                                     (grant_idx[gi] == IDX_W'(PORTS - 1)) ? '0 :
                                     grant_idx[gi] + 1'b1;

            assign data_o_en[gi] = !rst && grant_valid[gi];
            assign data_o[gi]    = data_o_en[gi] ? data_i[grant_idx[gi]] : '0;
        end

        for (gi = 0; gi < PORTS; gi++) begin : g_ret
            logic                owned;
            logic [BP_WIDTH-1:0] bp_sel;

            // An input can own at most one output, so at most one term matches.
            always_comb begin
                owned  = 1'b0;
                bp_sel = '0;
                for (int o = 0; o < PORTS; o++) begin
                    if (grant_valid[o] && (grant_idx[o] == IDX_W'(gi))) begin
                        owned  = 1'b1;
                        bp_sel = bp_i[o];
                    end
                end
            end

            assign ack[gi]  = !rst && owned;
            assign bp_o[gi] = ack[gi] ? bp_sel : '0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_valid_reg <= '0;
            owner_idx_reg   <= '0;
            rr_ptr_reg      <= '0;
        end else begin
            owner_valid_reg <= owner_valid_next;
            owner_idx_reg   <= owner_idx_next;
            rr_ptr_reg      <= rr_ptr_next;
        end
    end

endmodule

// File: tb/tb_crossbar_rr.sv
// Directed bench for crossbar_rr: reset, single path, contention/hold, fairness,
// parallel permutation and asynchronous reset during a live connection.
module tb_crossbar_rr;

    localparam int PORTS    = 4;
    localparam int WIDTH    = 8;
    localparam int BP_WIDTH = 2;

    logic                              clk = 1'b0;
    logic                              rst;
    logic [PORTS-1:0][WIDTH-1:0]       data_i;
    logic [PORTS-1:0][BP_WIDTH-1:0]    bp_i;
    logic [PORTS-1:0][1:0]             dest;
    logic [PORTS-1:0]                  dest_en;
    logic [PORTS-1:0][WIDTH-1:0]       data_o;
    logic [PORTS-1:0]                  data_o_en;
    logic [PORTS-1:0][BP_WIDTH-1:0]    bp_o;
    logic [PORTS-1:0]                  ack;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    crossbar_rr #(
        .PORTS    (PORTS),
        .WIDTH    (WIDTH),
        .BP_WIDTH (BP_WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_i    (data_i),
        .bp_i      (bp_i),
        .dest      (dest),
        .dest_en   (dest_en),
        .data_o    (data_o),
        .data_o_en (data_o_en),
        .bp_o      (bp_o),
        .ack       (ack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".ack"},  32'(ack), 32'h0);
        check({tag, ".en"},   32'(data_o_en), 32'h0);
        check({tag, ".data"}, 32'(data_o), 32'h0);
        check({tag, ".bp"},   32'(bp_o), 32'h0);
    endtask

    int fair_exp [5] = '{0, 1, 2, 3, 0};

    initial begin
        // Reset with arbitrary live requests
        rst     = 1'b1;
        data_i  = 32'hDEAD_BEEF;
        bp_i    = 8'hFF;
        dest    = 8'b00_01_10_11;
        dest_en = 4'hF;
        #3;
        check_idle("rst_busy");

        @(posedge clk);
        #3;
        rst     = 1'b0;
        dest_en = 4'h0;
        #1;
        check_idle("rst_rel");
        tick();
        check_idle("idle");

        // Single connection 0 -> 2
        data_i  = {8'h44, 8'h33, 8'h22, 8'hA5};
        bp_i    = {2'b01, 2'b10, 2'b11, 2'b11};
        dest    = '0;
        dest[0] = 2'd2;
        dest_en = 4'b0001;
        #1;
        check("single.ack",  32'(ack), 32'h1);
        check("single.en",   32'(data_o_en), 32'h4);
        check("single.data", 32'(data_o), 32'h00A5_0000);
        check("single.bp",   32'(bp_o), 32'h02);
        tick();
        dest_en = 4'h0;
        tick();

        // Contention on output 0 between inputs 1 and 3
        data_i  = {8'h33, 8'h00, 8'h11, 8'h00};
        dest    = '0;
        dest_en = 4'b1010;
        #1;
        check("cont.ack",  32'(ack), 32'h2);
        check("cont.data", 32'(data_o), 32'h0000_0011);
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("hold%0d.ack", c), 32'(ack), 32'h2);
        end
        dest_en = 4'b1000;
        #1;
        check("handover.ack",  32'(ack), 32'h8);
        check("handover.data", 32'(data_o), 32'h0000_0033);
        tick();
        check("hold3.ack", 32'(ack), 32'h8);
        dest_en = 4'b0000;
        #1;
        check("gap.ack", 32'(ack), 32'h0);
        check("gap.en",  32'(data_o_en), 32'h0);
        tick();
        dest_en = 4'b1010;
        #1;
        check("rr_ptr0.ack", 32'(ack), 32'h2);
        tick();
        dest_en = 4'b1000;
        #1;
        check("rr_ptr2.ack", 32'(ack), 32'h8);
        tick();
        dest_en = 4'b0010;
        #1;
        check("rr_swap.ack", 32'(ack), 32'h2);
        tick();
        dest_en = 4'b0000;
        tick();

        // Fairness on output 1: last winner drops for a cycle each time
        data_i  = {8'h13, 8'h12, 8'h11, 8'h10};
        dest    = {2'd1, 2'd1, 2'd1, 2'd1};
        dest_en = 4'hF;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) begin
                dest_en = 4'hF & ~(4'b0001 << fair_exp[c-1]);
            end
            #1;
            check($sformatf("fair%0d.ack", c), 32'(ack), 32'(4'b0001 << fair_exp[c]));
            check($sformatf("fair%0d.data", c), 32'(data_o), 32'(8'h10 + fair_exp[c]) << 8);
            tick();
        end
        dest_en = 4'h0;
        tick();

        // Parallel permutation 0->1, 1->2, 2->3, 3->0
        data_i  = {8'h44, 8'h33, 8'h22, 8'h11};
        bp_i    = {2'b00, 2'b11, 2'b10, 2'b01};
        dest    = {2'd0, 2'd3, 2'd2, 2'd1};
        dest_en = 4'hF;
        #1;
        check("par.ack",  32'(ack), 32'hF);
        check("par.en",   32'(data_o_en), 32'hF);
        check("par.data", 32'(data_o), 32'h3322_1144);
        check("par.bp",   32'(bp_o), 32'h4E);
        tick();
        check("par_hold.ack", 32'(ack), 32'hF);

        // Asynchronous reset between edges during the live permutation
        #2;
        rst = 1'b1;
        #1;
        check_idle("arst");
        dest    = {2'd3, 2'd3, 2'd3, 2'd0};
        dest_en = 4'b1110;
        data_i  = {8'h77, 8'h66, 8'h55, 8'h00};
        #1;
        check("arst_req.ack", 32'(ack), 32'h0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        // Output 3's pointer was 3 before reset; after clearing, input 1 wins.
        check("post_rst.ack",  32'(ack), 32'h2);
        check("post_rst.en",   32'(data_o_en), 32'h8);
        check("post_rst.data", 32'(data_o), 32'h5500_0000);
        tick();
        check("post_rst_hold.ack", 32'(ack), 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
